// File: rtl/cv_pad_ctrl.sv
// ColecoVision controller-port emulation: maps MiSTer joystick words onto the
// active-low keypad/joystick pin matrix, with a stretched keypad code and a quadrature spinner.
module cv_pad_ctrl #(
   parameter int          NPADS      = 2,
   parameter logic [15:0] HOLD_TICKS = 16'd4096,
   parameter logic [15:0] SPIN_DIV   = 16'd2048
) (
   input  logic                  clk_sys,
   input  logic                  reset,
   input  logic                  ce,
   input  logic                  swap,
   input  logic [32*NPADS-1:0]   joy_i,
   input  logic [NPADS-1:0]      p5_n_i,
   input  logic [NPADS-1:0]      p8_n_i,
   output logic [4*NPADS-1:0]    p1_4_o,
   output logic [NPADS-1:0]      p6_o,
   output logic [NPADS-1:0]      p7_o,
   output logic [NPADS-1:0]      p9_o
);

   localparam logic [3:0] NONE = 4'b1111;

   logic [21:0] src    [NPADS];
   logic [3:0]  enc    [NPADS];
   logic        key    [NPADS];
   logic [3:0]  held   [NPADS];
   logic [3:0]  held_n [NPADS];
   logic        act    [NPADS];
   logic        act_n  [NPADS];
   logic        prs    [NPADS];
   logic        prs_n  [NPADS];
   logic [15:0] hcnt   [NPADS];
   logic [15:0] hcnt_n [NPADS];
   logic [15:0] div    [NPADS];
   logic [15:0] div_n  [NPADS];
   logic [1:0]  ph     [NPADS];
   logic [1:0]  ph_n   [NPADS];
   logic [3:0]  pins_n [NPADS];
   logic        fire_n [NPADS];
   logic [3:0]  kp     [NPADS];
   logic [3:0]  js     [NPADS];
   logic        swap_q;
   logic        swap_chg;

   assign swap_chg = (NPADS >= 2) && (swap != swap_q);

   // Only ports 0 and 1 take part in the swap; higher ports stay wired straight.
   for (genvar p = 0; p < NPADS; p++) begin : g_pad
      logic [9:0] unused_hi;
      assign unused_hi = joy_i[32*p+22 +: 10];
      if (NPADS >= 2 && p < 2) begin : g_swp
         assign src[p] = swap ? joy_i[32*(1-p) +: 22] : joy_i[32*p +: 22];
      end else begin : g_fix
         assign src[p] = joy_i[32*p +: 22];
      end
   end

   always_comb begin
      for (int p = 0; p < NPADS; p++) begin
         enc[p]    = NONE;
         key[p]    = |src[p][19:6];
         held_n[p] = held[p];
         act_n[p]  = act[p];
         hcnt_n[p] = hcnt[p];
         prs_n[p]  = key[p];
         div_n[p]  = div[p];
         ph_n[p]   = ph[p];

         if      (src[p][8])  enc[p] = 4'b0011;
         else if (src[p][9])  enc[p] = 4'b1110;
         else if (src[p][10]) enc[p] = 4'b1101;
         else if (src[p][11]) enc[p] = 4'b0110;
         else if (src[p][12]) enc[p] = 4'b0001;
         else if (src[p][13]) enc[p] = 4'b1001;
         else if (src[p][14]) enc[p] = 4'b0111;
         else if (src[p][15]) enc[p] = 4'b1100;
         else if (src[p][16]) enc[p] = 4'b1000;
         else if (src[p][17]) enc[p] = 4'b1011;
         else if (src[p][6])  enc[p] = 4'b1010;
         else if (src[p][7])  enc[p] = 4'b0101;
         else if (src[p][18]) enc[p] = 4'b0100;
         else if (src[p][19]) enc[p] = 4'b0010;

         // A swap drops any stretched code from the old pad but still shows a key held on the new one.
         if (swap_chg) begin
            held_n[p] = key[p] ? enc[p] : NONE;
            act_n[p]  = 1'b0;
            hcnt_n[p] = 16'd0;
         end else if (key[p]) begin
            held_n[p] = enc[p];
            act_n[p]  = 1'b0;
            hcnt_n[p] = 16'd0;
         end else if (prs[p]) begin
            hcnt_n[p] = 16'd0;
            if (HOLD_TICKS == 16'd0) held_n[p] = NONE;
            else                     act_n[p]  = 1'b1;
         end else if (act[p] && ce) begin
            if (hcnt[p] + 16'd1 >= HOLD_TICKS) begin
               held_n[p] = NONE;
               act_n[p]  = 1'b0;
               hcnt_n[p] = 16'd0;
            end else begin
               hcnt_n[p] = hcnt[p] + 16'd1;
            end
         end

         kp[p]     = p5_n_i[p] ? NONE : held_n[p];
         js[p]     = p8_n_i[p] ? NONE : {~src[p][3], ~src[p][2], ~src[p][1], ~src[p][0]};
         pins_n[p] = kp[p] & js[p];
         fire_n[p] = (p5_n_i[p] | ~src[p][5]) & (p8_n_i[p] | ~src[p][4]);

         if (src[p][21] ^ src[p][20]) begin
            if (ce) begin
               if (div[p] + 16'd1 >= SPIN_DIV) begin
                  div_n[p] = 16'd0;
                  ph_n[p]  = src[p][21] ? ph[p] + 2'd1 : ph[p] - 2'd1;
               end else begin
                  div_n[p] = div[p] + 16'd1;
               end
            end
         end else begin
            div_n[p] = 16'd0;
         end
      end
   end

   // Gray decode of the phase: {A,B} = 11,10,00,01 for phases 0..3.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         swap_q <= 1'b0;
         p1_4_o <= '1;
         p6_o   <= '1;
         p7_o   <= '1;
         p9_o   <= '1;
         for (int p = 0; p < NPADS; p++) begin
            held[p] <= NONE;
            act[p]  <= 1'b0;
            prs[p]  <= 1'b0;
            hcnt[p] <= 16'd0;
            div[p]  <= 16'd0;
            ph[p]   <= 2'd0;
         end
      end else begin
         swap_q <= swap;
         for (int p = 0; p < NPADS; p++) begin
            held[p]          <= held_n[p];
            act[p]           <= act_n[p];
            prs[p]           <= prs_n[p];
            hcnt[p]          <= hcnt_n[p];
            div[p]           <= div_n[p];
            ph[p]            <= ph_n[p];
            p1_4_o[4*p +: 4] <= pins_n[p];
            p6_o[p]          <= fire_n[p];
            p7_o[p]          <= ~ph_n[p][1];
            p9_o[p]          <= ~(ph_n[p][1] ^ ph_n[p][0]);
         end
      end
   end

endmodule

// File: tb/tb_cv_pad_ctrl.sv
// Directed bench for cv_pad_ctrl: NPADS=2, HOLD_TICKS=4, SPIN_DIV=2, ce every 4th clock.
module tb_cv_pad_ctrl;

   logic        clk_sys = 1'b0;
   logic        reset;
   logic        ce;
   logic        swap;
   logic [63:0] joy;
   logic [1:0]  p5_n;
   logic [1:0]  p8_n;
   logic [7:0]  p1_4;
   logic [1:0]  p6;
   logic [1:0]  p7;
   logic [1:0]  p9;

   int n_chk  = 0;
   int n_fail = 0;

   cv_pad_ctrl #(.NPADS(2), .HOLD_TICKS(16'd4), .SPIN_DIV(16'd2)) dut (
      .clk_sys (clk_sys),
      .reset   (reset),
      .ce      (ce),
      .swap    (swap),
      .joy_i   (joy),
      .p5_n_i  (p5_n),
      .p8_n_i  (p8_n),
      .p1_4_o  (p1_4),
      .p6_o    (p6),
      .p7_o    (p7),
      .p9_o    (p9)
   );

   always #5 clk_sys = ~clk_sys;

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk_sys);
         #1;
      end
   endtask

   task automatic tick();
      ce = 1'b1;
      cyc(1);
      ce = 1'b0;
      cyc(3);
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      reset = 1'b1; ce = 1'b0; swap = 1'b0; joy = '0; p5_n = 2'b11; p8_n = 2'b11;
      cyc(3);
      chk("rst_p1_4", p1_4, 8'hFF);
      chk("rst_fire_spin", {2'b00, p6, p7, p9}, 8'h3F);
      reset = 1'b0;
      cyc(1);

      // digit 5 pulse, stretched for 4 ce ticks
      p5_n = 2'b10; joy = 64'd1 << 13;
      cyc(1);
      chk("d5_press", p1_4, 8'hF9);
      joy = '0;
      cyc(1);
      chk("d5_release", p1_4, 8'hF9);
      repeat (3) tick();
      chk("d5_hold3", p1_4, 8'hF9);
      ce = 1'b1; cyc(1); ce = 1'b0;
      chk("d5_clear", p1_4, 8'hFF);

      // priority and key replacement
      joy = (64'd1 << 11) | (64'd1 << 15);
      cyc(1);
      chk("d3_d7_prio", p1_4, 8'hF6);
      joy = 64'd1 << 15;
      cyc(1);
      chk("d7_after_d3", p1_4, 8'hFC);
      joy = '0;
      cyc(1);
      tick();
      chk("d7_in_hold", p1_4, 8'hFC);
      joy = 64'd1 << 17;
      cyc(1);
      chk("d9_replaces", p1_4, 8'hFB);
      joy = '0;
      cyc(1);
      repeat (2) tick();
      joy = 64'd1 << 17;
      cyc(1);
      joy = '0;
      cyc(1);
      repeat (3) tick();
      chk("repress_cancel", p1_4, 8'hFB);
      ce = 1'b1; cyc(1); ce = 1'b0;
      chk("repress_clear", p1_4, 8'hFF);

      // joystick/keypad AND and fire; port 1 keypad independently
      p5_n = 2'b00; p8_n = 2'b10;
      joy = (64'd1 << 3) | (64'd1 << 9) | (64'd1 << 4) | (64'd1 << 42);
      cyc(1);
      chk("kp_and_js", p1_4, 8'hD6);
      chk("fire1_sel", {6'd0, p6}, 8'h02);
      p5_n = 2'b11; joy = (64'd1 << 3) | (64'd1 << 9) | (64'd1 << 4);
      cyc(1);
      chk("js_only", p1_4, 8'hF7);
      chk("fire1_js_only", {6'd0, p6}, 8'h02);
      p5_n = 2'b10; p8_n = 2'b11; joy = 64'd1 << 5;
      cyc(1);
      chk("kp_hold_fire2", {p1_4[3:0], 2'b00, p6}, 8'hE2);
      p5_n = 2'b11;
      cyc(1);
      chk("fire2_desel", {6'd0, p6}, 8'h03);
      joy = '0;
      repeat (5) tick();

      // spinner, port 0
      joy = 64'd1 << 21;
      tick();
      chk("spin_r_half", {6'd0, p7[0], p9[0]}, 8'h03);
      tick();
      chk("spin_r1", {6'd0, p7[0], p9[0]}, 8'h02);
      repeat (2) tick();
      chk("spin_r2", {6'd0, p7[0], p9[0]}, 8'h00);
      repeat (2) tick();
      chk("spin_r3", {6'd0, p7[0], p9[0]}, 8'h01);
      repeat (2) tick();
      chk("spin_r_wrap", {4'd0, p7, p9}, 8'h0F);
      joy = 64'd1 << 20;
      repeat (2) tick();
      chk("spin_l_wrap", {6'd0, p7[0], p9[0]}, 8'h01);
      repeat (2) tick();
      chk("spin_l2", {6'd0, p7[0], p9[0]}, 8'h00);
      repeat (2) tick();
      chk("spin_l1", {6'd0, p7[0], p9[0]}, 8'h02);
      repeat (2) tick();
      chk("spin_l0", {6'd0, p7[0], p9[0]}, 8'h03);
      joy = 64'd1 << 21;
      repeat (2) tick();
      joy = 64'd3 << 20;
      repeat (4) tick();
      chk("spin_both_frozen", {6'd0, p7[0], p9[0]}, 8'h02);
      joy = 64'd1 << 21;
      tick();
      chk("spin_div_restart", {6'd0, p7[0], p9[0]}, 8'h02);
      tick();
      chk("spin_after_both", {6'd0, p7[0], p9[0]}, 8'h00);

      // swap with pad 1 digit 0 held
      joy = 64'd1 << 40; p5_n = 2'b10;
      cyc(1);
      chk("pre_swap", p1_4, 8'hFF);
      swap = 1'b1; p5_n = 2'b00;
      cyc(1);
      chk("swap_ports", p1_4, 8'hF3);
      chk("swap_phase_kept", {6'd0, p7[0], p9[0]}, 8'h00);
      swap = 1'b0; joy = '0; p5_n = 2'b11;
      cyc(1);

      // reset mid-hold and mid-spin
      joy = (64'd1 << 13) | (64'd1 << 21); p5_n = 2'b10;
      cyc(1);
      chk("pre_rst_code", p1_4, 8'hF9);
      joy = 64'd1 << 21;
      cyc(1);
      tick();
      reset = 1'b1;
      cyc(1);
      chk("mid_rst_p1_4", p1_4, 8'hFF);
      chk("mid_rst_fire_spin", {2'b00, p6, p7, p9}, 8'h3F);
      reset = 1'b0;
      tick();
      chk("post_rst_no_code", p1_4, 8'hFF);
      chk("post_rst_no_step", {6'd0, p7[0], p9[0]}, 8'h03);
      tick();
      chk("post_rst_step", {6'd0, p7[0], p9[0]}, 8'h02);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
